// File: rtl/fpc_pkg.sv
// Shared types and default geometry for the scanline fill controller.
package fpc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fpc_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int FPC_WIDTH_DEF  = 1600;
    localparam int FPC_HEIGHT_DEF = 900;
    localparam int FPC_XW         = 11;

endpackage

// File: rtl/fpc_sync2.sv
// Two-flop synchronizer for a pixel-domain strobe, with a one-cycle pulse on
// the synchronized falling edge.
module fpc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign level = sync;
    assign fall  = sync_q & ~sync;

endmodule

// File: rtl/fpc_linefill.sv
// Scanline fill controller: fetches the next display line from the framebuffer
// into the RGB scanline RAMs. Define FPC_LINEFILL_UNDERRUN_CNT_EN for the underrun counter.
module fpc_linefill
    import fpc_pkg::*;
#(
    parameter int WIDTH   = FPC_WIDTH_DEF,
    parameter int HEIGHT  = FPC_HEIGHT_DEF,
    parameter int AW      = 24,
    parameter int FB_BASE = 0,
    parameter int STRIDE  = 1600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              linesync,
    input  logic              framesync,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_ack,
    input  logic [23:0]       mem_rdata,
    output logic [FPC_XW-1:0] addr,
    output logic [7:0]        rdata,
    output logic [7:0]        gdata,
    output logic [7:0]        bdata,
    output logic              rwe,
    output logic              gwe,
    output logic              bwe,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [15:0]       underrun_cnt
);

    localparam int NLW = (HEIGHT < 1) ? 1 : $clog2(HEIGHT + 1);
    localparam logic [FPC_XW-1:0] X_LAST    = FPC_XW'(WIDTH - 1);
    localparam logic [AW-1:0]     BASE0     = AW'(FB_BASE);
    localparam logic [AW-1:0]     STEP      = AW'(STRIDE);
    localparam logic [NLW-1:0]    LAST_LINE = NLW'(HEIGHT);

    fpc_state_t        state;
    fpc_state_t        state_next;
    logic [FPC_XW-1:0] x;
    logic [AW-1:0]     line_base;
    logic [NLW-1:0]    next_line;
    logic              line_fall;
    logic              frame_lvl;
    logic              line_lvl_unused;
    logic              frame_fall_unused;
    logic              fill_go;
    logic [AW-1:0]     fill_base;
    logic              take;
    logic              underrun_evt;
    logic              we_q;
    rgb_t              pix_q;

    fpc_sync2 u_line_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (linesync),
        .level (line_lvl_unused),
        .fall  (line_fall)
    );

    fpc_sync2 u_frame_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (framesync),
        .level (frame_lvl),
        .fall  (frame_fall_unused)
    );

    // A line_fall selects the next line to fetch, or nothing during vertical blanking.
    always_comb begin
        fill_go   = 1'b0;
        fill_base = line_base;
        if (line_fall) begin
            if (frame_lvl) begin
                fill_go   = 1'b1;
                fill_base = BASE0;
            end else if (next_line < LAST_LINE) begin
                fill_go = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= BASE0;
            next_line <= '0;
        end else if (line_fall) begin
            if (frame_lvl) begin
                line_base <= BASE0 + STEP;
                next_line <= NLW'(1);
            end else if (next_line < LAST_LINE) begin
                line_base <= line_base + STEP;
                next_line <= next_line + NLW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Any trigger while filling aborts the current line; a blanking trigger leaves us idle.
    always_comb begin
        state_next   = state;
        take         = 1'b0;
        underrun_evt = 1'b0;
        case (state)
            IDLE: begin
                if (fill_go) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                take = mem_ack;
                if (line_fall) begin
                    underrun_evt = 1'b1;
                    state_next   = fill_go ? FILL : IDLE;
                end else if (mem_ack && (x == X_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            mem_addr <= BASE0;
            we_q     <= 1'b0;
            addr     <= '0;
            pix_q    <= '0;
        end else begin
            we_q <= take;
            if (take) begin
                addr  <= x;
                pix_q <= rgb_t'(mem_rdata);
            end
            if (fill_go) begin
                x        <= '0;
                mem_addr <= fill_base;
            end else if (take) begin
                x        <= x + FPC_XW'(1);
                mem_addr <= mem_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end else if (underrun_evt) begin
            underrun <= 1'b1;
        end
    end

`ifdef FPC_LINEFILL_UNDERRUN_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (underrun_clr) begin
            cnt <= '0;
        end else if (underrun_evt && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign underrun_cnt = cnt;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign busy    = (state == FILL);
    assign mem_req = busy;
    assign rwe     = we_q;
    assign gwe     = we_q;
    assign bwe     = we_q;
    assign rdata   = pix_q.r;
    assign gdata   = pix_q.g;
    assign bdata   = pix_q.b;

endmodule

// File: tb/tb_fpc_linefill.sv
// Self-checking bench for fpc_linefill using a small geometry and a line-number
// model of the framebuffer walk.
module tb_fpc_linefill;

    localparam int W    = 12;
    localparam int H    = 6;
    localparam int AWT  = 16;
    localparam int BASE = 32'hFFD0;
    localparam int STR  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           linesync;
    logic           framesync;
    logic           mem_req;
    logic [AWT-1:0] mem_addr;
    logic           mem_ack;
    logic [23:0]    mem_rdata;
    logic [10:0]    addr;
    logic [7:0]     rdata;
    logic [7:0]     gdata;
    logic [7:0]     bdata;
    logic           rwe;
    logic           gwe;
    logic           bwe;
    logic           busy;
    logic           underrun;
    logic           underrun_clr;
    logic [15:0]    underrun_cnt;

    int  tests    = 0;
    int  failures = 0;
    int  salt;
    int  m_line   = 0;
    bit  m_busy   = 1'b0;
    bit  u_flag   = 1'b0;
    int  u_cnt    = 0;

    fpc_linefill #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .AW      (AWT),
        .FB_BASE (BASE),
        .STRIDE  (STR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .linesync     (linesync),
        .framesync    (framesync),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .addr         (addr),
        .rdata        (rdata),
        .gdata        (gdata),
        .bdata        (bdata),
        .rwe          (rwe),
        .gwe          (gwe),
        .bwe          (bwe),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic int addrOf(input int v);
        return v & ((1 << AWT) - 1);
    endfunction

    function automatic int lineBaseOf(input int line);
        return addrOf(BASE + line * STR);
    endfunction

    function automatic logic [23:0] pixOf(input int a);
        return 24'((a * 32'h9E3779B1) ^ salt);
    endfunction

    function automatic int expCnt();
`ifdef FPC_LINEFILL_UNDERRUN_CNT_EN
        return u_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_maddr", mem_addr, addrOf(BASE));
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_rgb", {rdata, gdata, bdata}, 0);
        checkOutput("rst_we", {rwe, gwe, bwe}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_cnt", underrun_cnt, 0);
    endtask

    // Drive one linesync fall; returns whether a fill should start and from where.
    task automatic applyStimulus(input bit fs, output bit fills, output int base);
        int line = -1;
        if (fs) line = 0;
        else if (m_line < H) line = m_line;
        fills = (line >= 0);
        base  = fills ? lineBaseOf(line) : 0;
        if (fills) m_line = line + 1;
        if (m_busy) begin
            u_flag = 1'b1;
            if (u_cnt != 16'hFFFF) u_cnt++;
        end
        framesync = fs;
        linesync  = 1'b1;
        repeat (3) @(negedge clk);
        linesync = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("req_before_trig", mem_req, m_busy);
        @(negedge clk);
        checkOutput("req_after_trig", mem_req, fills);
        checkOutput("underrun_flag", underrun, u_flag);
        m_busy = fills;
    endtask

    // mode 0: ack every cycle, 1: alternate cycles, 2: random. Stops after stop_at acks.
    task automatic runFill(input int base, input int mode, input int stop_at);
        int k     = 0;
        int guard = 0;
        bit acked = 1'b0;
        forever begin
            checkOutput("busy", busy, k < W);
            checkOutput("req", mem_req, k < W);
            if (k < W) checkOutput("mem_addr", mem_addr, addrOf(base + k));
            checkOutput("we", {rwe, gwe, bwe}, {3{acked}});
            if (acked) begin
                checkOutput("waddr", addr, k - 1);
                checkOutput("wdata", {rdata, gdata, bdata}, pixOf(addrOf(base + k - 1)));
            end
            if (k == stop_at) break;
            if (guard > 40 * W) begin
                checkOutput("fill_timeout", k, stop_at);
                break;
            end
            case (mode)
                0:       acked = 1'b1;
                1:       acked = guard[0];
                default: acked = ($urandom_range(99) < 60);
            endcase
            mem_ack   = acked;
            mem_rdata = pixOf(addrOf(base + k));
            @(negedge clk);
            if (acked) k++;
            guard++;
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        m_busy    = (k < W);
    endtask

    task automatic checkIdle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("blank_req", mem_req, 0);
            checkOutput("blank_we", rwe, 0);
        end
    endtask

    initial begin
        bit fills;
        int base;
        salt         = int'($urandom);
        rst_n        = 1'b0;
        linesync     = 1'b0;
        framesync    = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        @(negedge clk);
        checkReset();

        // Steady line, then a stalled line, then random-ack lines to the bottom.
        applyStimulus(1'b0, fills, base);
        runFill(base, 0, W);
        applyStimulus(1'b0, fills, base);
        runFill(base, 1, W);
        for (int l = 2; l < H; l++) begin
            applyStimulus(1'b0, fills, base);
            runFill(base, 2, W);
        end
        checkOutput("underrun_steady", underrun, 0);

        // Vertical blanking triggers must not fetch anything.
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b0, fills, base);
            checkOutput("blank_fills", fills, 0);
            checkIdle(4);
        end

        // Frame wrap restarts at line 0.
        applyStimulus(1'b1, fills, base);
        checkOutput("wrap_base", base, addrOf(BASE));
        runFill(base, 2, W);

        // Underrun: stall mid-line and trigger the next line.
        applyStimulus(1'b0, fills, base);
        runFill(base, 0, 4);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, fills, base);
        checkOutput("underrun_set", underrun, 1);
        checkOutput("underrun_cnt", underrun_cnt, expCnt());
        runFill(base, 2, W);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        u_flag = 1'b0;
        u_cnt  = 0;
        checkOutput("underrun_clr", underrun, u_flag);
        checkOutput("underrun_cnt_clr", underrun_cnt, expCnt());

        // Reset in the middle of a fill.
        applyStimulus(1'b0, fills, base);
        runFill(base, 0, 5);
        rst_n = 1'b0;
        #1;
        checkReset();
        m_line = 0;
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, fills, base);
        checkOutput("post_reset_base", base, addrOf(BASE));
        runFill(base, 0, W);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
